// File: rtl/bin_load_update_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_load_update_pkg
// Description : Shared sat package: bin geometry, datapath widths and the
//               state encoding of the bin load/update controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_load_update_pkg;

    // Bin geometry
    localparam int c_NUM_CLAUSES      = 8;
    localparam int c_NUM_VARS         = 8;
    localparam int c_NUM_LVLS         = 8;

    // Datapath widths
    localparam int c_WIDTH_BIN_ID     = 10;
    localparam int c_WIDTH_LVL        = 16;
    localparam int c_WIDTH_VAR_STATES = 19;
    localparam int c_WIDTH_LVL_STATES = 11;

    // Controller state encoding
    localparam int         c_STATE_W   = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LD_C   = 3'd1;
    localparam logic [2:0] c_ST_LD_S   = 3'd2;
    localparam logic [2:0] c_ST_START  = 3'd3;
    localparam logic [2:0] c_ST_WAIT   = 3'd4;
    localparam logic [2:0] c_ST_UPD_C  = 3'd5;
    localparam logic [2:0] c_ST_UPD_S  = 3'd6;
    localparam logic [2:0] c_ST_DONE   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/bin_load_update_addr_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bin_addr_cnt
// Description : Clause index sequencer shared by the load and update phases.
//               While i_run is high it issues indices 0..NUM_IDX-1 on
//               consecutive cycles, then raises o_last for one extra cycle.
//               o_strb / o_strb_idx follow each issued index one cycle later,
//               covering the one-cycle latency of the memory or core read.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_addr_cnt #(
    parameter int NUM_IDX = 8,
    parameter int IDX_W   = $clog2(NUM_IDX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    output logic               o_issue,
    output logic [IDX_W-1:0]   o_idx,
    output logic [NUM_IDX-1:0] o_onehot,
    output logic [NUM_IDX-1:0] o_strb,
    output logic [IDX_W-1:0]   o_strb_idx,
    output logic               o_last
);

    localparam int               c_CNT_W = $clog2(NUM_IDX + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_IDX);

    logic [c_CNT_W-1:0] r_cnt;
    logic [NUM_IDX-1:0] r_strb;
    logic [IDX_W-1:0]   r_strb_idx;

    // Counter value NUM_IDX is the trailing cycle that drains the last strobe
    assign o_issue    = i_run && (r_cnt != c_LAST);
    assign o_last     = i_run && (r_cnt == c_LAST);
    assign o_idx      = r_cnt[IDX_W-1:0];
    assign o_onehot   = {{(NUM_IDX-1){1'b0}}, 1'b1} << o_idx;
    assign o_strb     = r_strb;
    assign o_strb_idx = r_strb_idx;

    // Index counter: parks at zero whenever the phase is not running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (!o_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed one-hot strobe and index of the previously issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strb     <= '0;
            r_strb_idx <= '0;
        end else begin
            r_strb     <= o_issue ? o_onehot : '0;
            r_strb_idx <= o_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin_load_update.sv
`default_nettype none
// ============================================================================
// Module      : bin_load_update
// Description : Loads one bin (clauses plus variable/level state) from the
//               clause and state memories into the solver core, starts the
//               core, and on a satisfiable result writes the bin back.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_load_update
    import bin_load_update_pkg::*;
#(
    parameter int NUM_CLAUSES      = c_NUM_CLAUSES,
    parameter int NUM_VARS         = c_NUM_VARS,
    parameter int NUM_LVLS         = c_NUM_LVLS,
    parameter int WIDTH_BIN_ID     = c_WIDTH_BIN_ID,
    parameter int WIDTH_LVL        = c_WIDTH_LVL,
    parameter int WIDTH_VAR_STATES = c_WIDTH_VAR_STATES,
    parameter int WIDTH_LVL_STATES = c_WIDTH_LVL_STATES
) (
    input  logic                                       clk,
    input  logic                                       rst,
    // Control
    input  logic                                       start_i,
    input  logic [WIDTH_BIN_ID-1:0]                    bin_id_i,
    input  logic [WIDTH_LVL-1:0]                       load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                       base_lvl_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       sat_o,
    output logic                                       unsat_o,
    // Solver core
    output logic                                       start_core_o,
    input  logic                                       done_core_i,
    input  logic                                       sat_i,
    input  logic                                       unsat_i,
    output logic [WIDTH_LVL-1:0]                       cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                       load_lvl_o,
    output logic                                       base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                       base_lvl_o,
    output logic [NUM_CLAUSES-1:0]                     rd_carray_o,
    output logic [NUM_CLAUSES-1:0]                     wr_carray_o,
    output logic [NUM_VARS*2-1:0]                      clause_o,
    input  logic [NUM_VARS*2-1:0]                      clause_i,
    output logic [NUM_VARS-1:0]                        wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]       vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]       vars_states_i,
    output logic [NUM_LVLS-1:0]                        wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]       lvl_states_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]       lvl_states_i,
    // Clause memory
    output logic                                       cm_rd_o,
    output logic                                       cm_wr_o,
    output logic [WIDTH_BIN_ID+$clog2(NUM_CLAUSES)-1:0] cm_addr_o,
    output logic [NUM_VARS*2-1:0]                      cm_wdata_o,
    input  logic [NUM_VARS*2-1:0]                      cm_rdata_i,
    // State memory
    output logic                                       sm_rd_o,
    output logic                                       sm_wr_o,
    output logic [WIDTH_BIN_ID-1:0]                    sm_addr_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]       sm_vs_rdata_i,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]       sm_vs_wdata_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]       sm_ls_rdata_i,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]       sm_ls_wdata_o
);

    localparam int c_IDX_W = $clog2(NUM_CLAUSES);

    logic [c_STATE_W-1:0]    r_state;
    logic [c_STATE_W-1:0]    w_state_nxt;
    logic [WIDTH_BIN_ID-1:0] r_bin;
    logic [WIDTH_LVL-1:0]    r_load_lvl;
    logic [WIDTH_LVL-1:0]    r_base_lvl;
    logic                    r_lds_ph;
    logic                    r_sat;
    logic                    r_unsat;
    logic [NUM_VARS*2-1:0]   r_clause_wb;

    logic                    w_idle;
    logic                    w_ldc;
    logic                    w_lds;
    logic                    w_wait;
    logic                    w_updc;
    logic                    w_upds;
    logic                    w_accept;
    logic                    w_ls_wr;
    logic                    w_run;
    logic                    w_issue;
    logic                    w_last;
    logic [c_IDX_W-1:0]      w_idx;
    logic [NUM_CLAUSES-1:0]  w_onehot;
    logic [NUM_CLAUSES-1:0]  w_strb;
    logic [c_IDX_W-1:0]      w_strb_idx;
    logic                    w_strb_any;

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_ldc      = (r_state == c_ST_LD_C);
    assign w_lds      = (r_state == c_ST_LD_S);
    assign w_wait     = (r_state == c_ST_WAIT);
    assign w_updc     = (r_state == c_ST_UPD_C);
    assign w_upds     = (r_state == c_ST_UPD_S);
    assign w_accept   = w_idle && start_i;
    assign w_ls_wr    = w_lds && r_lds_ph;
    assign w_run      = w_ldc || w_updc;
    assign w_strb_any = |w_strb;

    // One sequencer serves both the clause load and the clause writeback
    bin_addr_cnt #(
        .NUM_IDX    (NUM_CLAUSES),
        .IDX_W      (c_IDX_W)
    ) u_addr_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_run      (w_run),
        .o_issue    (w_issue),
        .o_idx      (w_idx),
        .o_onehot   (w_onehot),
        .o_strb     (w_strb),
        .o_strb_idx (w_strb_idx),
        .o_last     (w_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a core result with unsat set skips writeback
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start_i)     w_state_nxt = c_ST_LD_C;
            c_ST_LD_C:  if (w_last)      w_state_nxt = c_ST_LD_S;
            c_ST_LD_S:  if (r_lds_ph)    w_state_nxt = c_ST_START;
            c_ST_START:                  w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (done_core_i) w_state_nxt = unsat_i ? c_ST_DONE : c_ST_UPD_C;
            c_ST_UPD_C: if (w_last)      w_state_nxt = c_ST_UPD_S;
            c_ST_UPD_S:                  w_state_nxt = c_ST_DONE;
            c_ST_DONE:                   w_state_nxt = c_ST_IDLE;
            default:                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Request parameters are captured once and held for the whole job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin      <= '0;
            r_load_lvl <= '0;
            r_base_lvl <= '0;
        end else if (w_accept) begin
            r_bin      <= bin_id_i;
            r_load_lvl <= load_lvl_i;
            r_base_lvl <= base_lvl_i;
        end
    end

    // State-load phase: first cycle reads memory, second cycle writes core
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lds_ph <= 1'b0;
        end else begin
            r_lds_ph <= w_lds && !r_lds_ph;
        end
    end

    // Core verdict; sat and unsat together resolve to unsat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat   <= 1'b0;
            r_unsat <= 1'b0;
        end else if (w_accept) begin
            r_sat   <= 1'b0;
            r_unsat <= 1'b0;
        end else if (w_wait && done_core_i) begin
            r_sat   <= sat_i && !unsat_i;
            r_unsat <= unsat_i;
        end
    end

    // Core clause read is combinational; stage it before the memory write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clause_wb <= '0;
        end else if (w_updc && w_issue) begin
            r_clause_wb <= clause_i;
        end
    end

    // Control/status
    assign busy_o        = !w_idle;
    assign done_o        = (r_state == c_ST_DONE);
    assign sat_o         = done_o && r_sat;
    assign unsat_o       = done_o && r_unsat;

    // Core interface
    assign start_core_o    = (r_state == c_ST_START);
    assign cur_bin_num_o   = {{(WIDTH_LVL-WIDTH_BIN_ID){1'b0}}, r_bin};
    assign load_lvl_o      = r_load_lvl;
    assign base_lvl_o      = r_base_lvl;
    assign base_lvl_en_o   = w_ls_wr;
    assign wr_carray_o     = w_ldc ? w_strb : '0;
    assign clause_o        = (w_ldc && w_strb_any) ? cm_rdata_i : '0;
    assign rd_carray_o     = (w_updc && w_issue) ? w_onehot : '0;
    assign wr_var_states_o = {NUM_VARS{w_ls_wr}};
    assign wr_lvl_states_o = {NUM_LVLS{w_ls_wr}};
    assign vars_states_o   = w_ls_wr ? sm_vs_rdata_i : '0;
    assign lvl_states_o    = w_ls_wr ? sm_ls_rdata_i : '0;

    // Clause memory: reads during load, staged writes during update
    assign cm_rd_o    = w_ldc && w_issue;
    assign cm_wr_o    = w_updc && w_strb_any;
    assign cm_addr_o  = cm_rd_o ? {r_bin, w_idx} :
                        cm_wr_o ? {r_bin, w_strb_idx} : '0;
    assign cm_wdata_o = cm_wr_o ? r_clause_wb : '0;

    // State memory
    assign sm_rd_o       = w_lds && !r_lds_ph;
    assign sm_wr_o       = w_upds;
    assign sm_addr_o     = (sm_rd_o || sm_wr_o) ? r_bin : '0;
    assign sm_vs_wdata_o = w_upds ? vars_states_i : '0;
    assign sm_ls_wdata_o = w_upds ? lvl_states_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_bin_load_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_load_update
// Description : Scoreboard bench for bin_load_update with clause/state memory
//               models and directed load, writeback, unsat and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_load_update;

    localparam int K_WRC = 1, K_SMLD = 2, K_START = 3, K_CMWR = 4, K_SMWR = 5, K_DONE = 6;

    typedef struct {
        int            kind;
        logic [31:0]   d0;
        logic [151:0]  d1;
        logic [87:0]   d2;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i, done_core_i, sat_i, unsat_i;
    logic [9:0]   bin_id_i;
    logic [15:0]  load_lvl_i, base_lvl_i;
    logic         busy_o, done_o, sat_o, unsat_o, start_core_o, base_lvl_en_o;
    logic [15:0]  cur_bin_num_o, load_lvl_o, base_lvl_o;
    logic [7:0]   rd_carray_o, wr_carray_o, wr_var_states_o, wr_lvl_states_o;
    logic [15:0]  clause_o, clause_i;
    logic [151:0] vars_states_o, vars_states_i;
    logic [87:0]  lvl_states_o, lvl_states_i;
    logic         cm_rd_o, cm_wr_o, sm_rd_o, sm_wr_o;
    logic [12:0]  cm_addr_o;
    logic [15:0]  cm_wdata_o;
    logic [15:0]  cm_rdata_i = '0;
    logic [9:0]   sm_addr_o;
    logic [151:0] sm_vs_rdata_i = '0, sm_vs_wdata_o;
    logic [87:0]  sm_ls_rdata_i = '0, sm_ls_wdata_o;

    logic [15:0]  cmem     [0:8191];
    logic [151:0] smem_vs  [0:1023];
    logic [87:0]  smem_ls  [0:1023];

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t_acc = 0;
    int   t_dc = 0;

    localparam logic [151:0] VS3 = {8{19'h12345}};
    localparam logic [87:0]  LS3 = {8{11'h2A5}};
    localparam logic [151:0] VS5 = {8{19'h7ABCD}};
    localparam logic [87:0]  LS5 = {8{11'h15A}};
    localparam logic [151:0] VS7 = {8{19'h40001}};
    localparam logic [87:0]  LS7 = {8{11'h401}};
    localparam logic [151:0] CVA = {8{19'h3C3C3}};
    localparam logic [87:0]  CLA = {8{11'h0F0}};
    localparam logic [151:0] CVB = {8{19'h0F0F0}};
    localparam logic [87:0]  CLB = {8{11'h70F}};

    bin_load_update dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .bin_id_i        (bin_id_i),
        .load_lvl_i      (load_lvl_i),
        .base_lvl_i      (base_lvl_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .sat_o           (sat_o),
        .unsat_o         (unsat_o),
        .start_core_o    (start_core_o),
        .done_core_i     (done_core_i),
        .sat_i           (sat_i),
        .unsat_i         (unsat_i),
        .cur_bin_num_o   (cur_bin_num_o),
        .load_lvl_o      (load_lvl_o),
        .base_lvl_en_o   (base_lvl_en_o),
        .base_lvl_o      (base_lvl_o),
        .rd_carray_o     (rd_carray_o),
        .wr_carray_o     (wr_carray_o),
        .clause_o        (clause_o),
        .clause_i        (clause_i),
        .wr_var_states_o (wr_var_states_o),
        .vars_states_o   (vars_states_o),
        .vars_states_i   (vars_states_i),
        .wr_lvl_states_o (wr_lvl_states_o),
        .lvl_states_o    (lvl_states_o),
        .lvl_states_i    (lvl_states_i),
        .cm_rd_o         (cm_rd_o),
        .cm_wr_o         (cm_wr_o),
        .cm_addr_o       (cm_addr_o),
        .cm_wdata_o      (cm_wdata_o),
        .cm_rdata_i      (cm_rdata_i),
        .sm_rd_o         (sm_rd_o),
        .sm_wr_o         (sm_wr_o),
        .sm_addr_o       (sm_addr_o),
        .sm_vs_rdata_i   (sm_vs_rdata_i),
        .sm_vs_wdata_o   (sm_vs_wdata_o),
        .sm_ls_rdata_i   (sm_ls_rdata_i),
        .sm_ls_wdata_o   (sm_ls_wdata_o)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models with one-cycle read latency
    always @(posedge clk) begin
        if (cm_rd_o) cm_rdata_i <= cmem[cm_addr_o];
        if (cm_wr_o) cmem[cm_addr_o] <= cm_wdata_o;
        if (sm_rd_o) begin
            sm_vs_rdata_i <= smem_vs[sm_addr_o];
            sm_ls_rdata_i <= smem_ls[sm_addr_o];
        end
        if (sm_wr_o) begin
            smem_vs[sm_addr_o] <= sm_vs_wdata_o;
            smem_ls[sm_addr_o] <= sm_ls_wdata_o;
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_WRC:   return "clause_load";
            K_SMLD:  return "state_load";
            K_START: return "start_core";
            K_CMWR:  return "clause_writeback";
            K_SMWR:  return "state_writeback";
            K_DONE:  return "done";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] a, input logic [151:0] b, input logic [87:0] c);
        exp_t e;
        e.kind = k; e.d0 = a; e.d1 = b; e.d2 = c;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input int k, input logic [31:0] a, input logic [151:0] b, input logic [87:0] c);
        exp_t e;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event d0=%h d1=%h, none required", kname(k), a, b);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.d0 !== a || e.d1 !== b || e.d2 !== c) begin
                n_fail++;
                $display("FAIL %s: got %s d0=%h d1=%h d2=%h, required %s d0=%h d1=%h d2=%h",
                         kname(e.kind), kname(k), a, b, c, kname(e.kind), e.d0, e.d1, e.d2);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every DUT output event is matched against the scoreboard
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if ((cm_rd_o && cm_wr_o) || (sm_rd_o && sm_wr_o)) begin
                n_cmp++;
                n_fail++;
                $display("FAIL strobe_exclusive: cm_rd=%b cm_wr=%b sm_rd=%b sm_wr=%b", cm_rd_o, cm_wr_o, sm_rd_o, sm_wr_o);
            end
            if (wr_carray_o != '0)
                sb_pop(K_WRC, {8'h0, wr_carray_o, clause_o}, '0, '0);
            if (base_lvl_en_o || wr_var_states_o != '0 || wr_lvl_states_o != '0)
                sb_pop(K_SMLD, {wr_var_states_o, wr_lvl_states_o, base_lvl_o}, vars_states_o, lvl_states_o);
            if (start_core_o)
                sb_pop(K_START, {cur_bin_num_o, load_lvl_o}, 152'(cyc - t_acc), '0);
            if (cm_wr_o)
                sb_pop(K_CMWR, {3'b0, cm_addr_o, cm_wdata_o}, '0, '0);
            if (sm_wr_o)
                sb_pop(K_SMWR, {22'h0, sm_addr_o}, sm_vs_wdata_o, sm_ls_wdata_o);
            if (done_o)
                sb_pop(K_DONE, {30'h0, sat_o, unsat_o}, 152'(cyc - t_dc), '0);
        end
    end

    // Expected load sequence: 8 clause strobes, state load, core start
    task automatic push_load(input int bin, input logic [15:0] ll, input logic [15:0] bl,
                             input logic [15:0] cbase, input logic [151:0] vs, input logic [87:0] ls);
        for (int k = 0; k < 8; k++)
            push(K_WRC, {8'h0, 8'(1 << k), cbase + 16'(k)}, '0, '0);
        push(K_SMLD, {8'hFF, 8'hFF, bl}, vs, ls);
        push(K_START, {16'(bin), ll}, 152'd11, '0);
    endtask

    task automatic push_wb(input int bin, input logic [15:0] cw, input logic [151:0] vs, input logic [87:0] ls);
        for (int k = 0; k < 8; k++)
            push(K_CMWR, {3'b0, 13'(bin * 8 + k), cw}, '0, '0);
        push(K_SMWR, 32'(bin), vs, ls);
    endtask

    task automatic drive_start(input logic [9:0] bin, input logic [15:0] ll, input logic [15:0] bl);
        start_i = 1'b1; bin_id_i = bin; load_lvl_i = ll; base_lvl_i = bl;
        t_acc = cyc + 1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_start_core();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (start_core_o) seen = 1;
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_start_core: got no start_core_o within 40 cycles, required one");
        end
    endtask

    task automatic core_done(input logic s, input logic u, input logic [15:0] cw,
                             input logic [151:0] vs, input logic [87:0] ls);
        done_core_i = 1'b1; sat_i = s; unsat_i = u;
        clause_i = cw; vars_states_i = vs; lvl_states_i = ls;
        t_dc = cyc;
        @(negedge clk);
        done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done_o) seen = 1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_done: got no done_o within 40 cycles, required one");
        end
        @(negedge clk);
    endtask

    initial begin
        bit found;
        rst = 1'b1; start_i = 1'b0; done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0;
        bin_id_i = '0; load_lvl_i = '0; base_lvl_i = '0;
        clause_i = '0; vars_states_i = '0; lvl_states_i = '0;
        for (int i = 0; i < 8192; i++) cmem[i] <= 16'hDEAD;
        for (int i = 0; i < 1024; i++) begin smem_vs[i] <= '0; smem_ls[i] <= '0; end
        for (int k = 0; k < 8; k++) begin
            cmem[24 + k] <= 16'h0001 + 16'(k);
            cmem[40 + k] <= 16'h5000 + 16'(k);
            cmem[56 + k] <= 16'h7000 + 16'(k);
        end
        smem_vs[3] <= VS3; smem_ls[3] <= LS3;
        smem_vs[5] <= VS5; smem_ls[5] <= LS5;
        smem_vs[7] <= VS7; smem_ls[7] <= LS7;
        repeat (3) @(negedge clk);

        chk("reset_strobes", {busy_o, done_o, sat_o, unsat_o, start_core_o, base_lvl_en_o,
            cm_rd_o, cm_wr_o, sm_rd_o, sm_wr_o, wr_carray_o, rd_carray_o, wr_var_states_o, wr_lvl_states_o}, '0);
        chk("reset_latched", {cur_bin_num_o, load_lvl_o, base_lvl_o}, '0);

        // Bin 3 load, start held during WAIT, sat writeback of 0xAAAA
        push_load(3, 16'h1234, 16'h0042, 16'h0001, VS3, LS3);
        rst = 1'b0;
        drive_start(10'd3, 16'h1234, 16'h0042);
        wait_start_core();
        start_i = 1'b1; bin_id_i = 10'd9;
        repeat (4) @(negedge clk);
        start_i = 1'b0;
        chk("wait_holds_busy", {busy_o, cur_bin_num_o}, {1'b1, 16'd3});
        push_wb(3, 16'hAAAA, CVA, CLA);
        push(K_DONE, {30'h0, 2'b10}, 152'd11, '0);
        core_done(1'b1, 1'b0, 16'hAAAA, CVA, CLA);
        wait_done();
        chk("cmem_wb_first", cmem[24], 16'hAAAA);
        chk("cmem_wb_last", cmem[31], 16'hAAAA);

        // Bin 7, sat and unsat together: no writeback, done one cycle later
        push_load(7, 16'hFFFF, 16'h8001, 16'h7000, VS7, LS7);
        push(K_DONE, {30'h0, 2'b01}, 152'd1, '0);
        drive_start(10'd7, 16'hFFFF, 16'h8001);
        wait_start_core();
        repeat (2) @(negedge clk);
        core_done(1'b1, 1'b1, 16'h1111, CVB, CLB);
        wait_done();
        chk("cmem_untouched", cmem[56], 16'h7000);

        // done_core_i in IDLE must be ignored
        done_core_i = 1'b1; sat_i = 1'b1;
        @(negedge clk);
        done_core_i = 1'b0; sat_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ignores_done", {busy_o, start_core_o}, '0);
        chk("scoreboard_empty_mid", 64'(sbq.size()), '0);

        // Bin 5: reset while index 4 is being read, then reload from index 0
        for (int k = 0; k < 4; k++)
            push(K_WRC, {8'h0, 8'(1 << k), 16'h5000 + 16'(k)}, '0, '0);
        drive_start(10'd5, 16'h0055, 16'h0005);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (cm_rd_o && cm_addr_o == 13'd44) found = 1;
            else @(negedge clk);
        end
        chk("reached_index4", {63'h0, found}, 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("midload_reset_strobes", {busy_o, done_o, start_core_o, base_lvl_en_o,
            cm_rd_o, cm_wr_o, sm_rd_o, sm_wr_o, wr_carray_o, rd_carray_o, wr_var_states_o, wr_lvl_states_o}, '0);
        chk("midload_reset_latched", {cur_bin_num_o, load_lvl_o, base_lvl_o}, '0);
        @(negedge clk);
        push_load(5, 16'h0055, 16'h0005, 16'h5000, VS5, LS5);
        rst = 1'b0;
        drive_start(10'd5, 16'h0055, 16'h0005);
        wait_start_core();
        @(negedge clk);
        push_wb(5, 16'h5555, CVB, CLB);
        push(K_DONE, {30'h0, 2'b10}, 152'd11, '0);
        core_done(1'b1, 1'b0, 16'h5555, CVB, CLB);
        wait_done();

        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty_final", 64'(sbq.size()), '0);
        chk("final_idle", {busy_o, done_o}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
